// File: rtl/ram_lane_init.sv
// Simple dual-port RAM with per-lane write enables, read-valid handshake,
// optional output register, selectable read-during-write and zero-init sequencer.
module ram_lane_init #(
  parameter int ADDR_LEN  = 16,
  parameter int DATA_LEN  = 32,
  parameter int LANE_LEN  = 8,
  parameter int OUT_REG   = 0,
  parameter int RDW_MODE  = 0,
  parameter int INIT_ZERO = 1
) (
  input  logic                           CLK,
  input  logic                           RST_N,
  input  logic                           wr_en,
  input  logic [DATA_LEN/LANE_LEN-1:0]   wr_be,
  input  logic [ADDR_LEN-1:0]            wr_addr,
  input  logic [DATA_LEN-1:0]            wr_data,
  input  logic                           rd_en,
  input  logic [ADDR_LEN-1:0]            rd_addr,
  output logic [DATA_LEN-1:0]            Q,
  output logic                           rd_valid,
  output logic                           busy
);

  localparam int LANES   = DATA_LEN / LANE_LEN;
  localparam int DATA_WS = 2 ** ADDR_LEN;

  typedef enum logic {INIT, READY} state_t;
  localparam state_t RST_STATE = (INIT_ZERO != 0) ? INIT : READY;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_LEN-1:0]   init_cnt;
  logic [ADDR_LEN-1:0]   init_cnt_nxt;

  logic [DATA_LEN-1:0]   mem [DATA_WS];

  logic                  mem_we;
  logic [ADDR_LEN-1:0]   mem_waddr;
  logic [DATA_LEN-1:0]   mem_wdata;
  logic [LANES-1:0]      mem_wbe;
  logic                  rd_acc;
  logic                  same_addr;
  logic [DATA_LEN-1:0]   rd_word;

  logic                  vld_p0;
  logic [DATA_LEN-1:0]   data_p0;

  function automatic logic [DATA_LEN-1:0] lane_merge(
    input logic [DATA_LEN-1:0] base,
    input logic [DATA_LEN-1:0] upd,
    input logic [LANES-1:0]    be
  );
    logic [DATA_LEN-1:0] r;
    r = base;
    for (int i = 0; i < LANES; i++) begin
      if (be[i]) r[i*LANE_LEN +: LANE_LEN] = upd[i*LANE_LEN +: LANE_LEN];
    end
    return r;
  endfunction

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= RST_STATE;
      init_cnt <= '0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
    end
  end

  // The sequencer owns the write port while clearing; user traffic is dropped.
  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    mem_we       = 1'b0;
    mem_waddr    = wr_addr;
    mem_wdata    = wr_data;
    mem_wbe      = wr_be;
    rd_acc       = 1'b0;
    case (state)
      INIT: begin
        mem_we       = 1'b1;
        mem_waddr    = init_cnt;
        mem_wdata    = '0;
        mem_wbe      = '1;
        init_cnt_nxt = init_cnt + ADDR_LEN'(1);
        if (&init_cnt) state_nxt = READY;
      end
      READY: begin
        mem_we = wr_en & (|wr_be);
        rd_acc = rd_en;
      end
      default: state_nxt = READY;
    endcase
  end

  assign busy = (state == INIT);

  always_ff @(posedge CLK) begin
    if (mem_we) begin
      for (int i = 0; i < LANES; i++) begin
        if (mem_wbe[i]) mem[mem_waddr][i*LANE_LEN +: LANE_LEN] <= mem_wdata[i*LANE_LEN +: LANE_LEN];
      end
    end
  end

  // Forwarding only merges the lanes being written this edge.
  always_comb begin
    same_addr = wr_en && (wr_addr == rd_addr);
    rd_word   = mem[rd_addr];
    if ((RDW_MODE != 0) && same_addr) rd_word = lane_merge(mem[rd_addr], wr_data, wr_be);
  end

  // Stage p0: array read
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
    end else begin
      vld_p0 <= rd_acc;
      if (rd_acc) data_p0 <= rd_word;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                vld_p1;
      logic [DATA_LEN-1:0] data_p1;

      // Stage p1: output register
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          vld_p1  <= 1'b0;
          data_p1 <= '0;
        end else begin
          vld_p1 <= vld_p0;
          if (vld_p0) data_p1 <= data_p0;
        end
      end

      assign Q        = data_p1;
      assign rd_valid = vld_p1;
    end else begin : g_no_out_reg
      assign Q        = data_p0;
      assign rd_valid = vld_p0;
    end
  endgenerate

endmodule

// File: doc/ram_lane_init.md
Name: ram_lane_init

Overview:
- Parametrised simple dual-port synchronous RAM with one write port and one read port.
- Adds per-lane (byte) write enables, a read-valid handshake, an optional output register stage, selectable read-during-write behaviour, and an automatic zero-initialisation sequencer after reset.
- Drop-in storage primitive for matrix/buffer datapaths that need known-zero contents and partial-word writes.

Parameters:
- ADDR_LEN, 16, address width; depth DATA_WS = 2**ADDR_LEN words.
- DATA_LEN, 32, word width; must be an integer multiple of LANE_LEN.
- LANE_LEN, 8, bits per write-enable lane; LANES = DATA_LEN/LANE_LEN.
- OUT_REG, 0, 0 = read latency 1, 1 = read latency 2 (extra output register).
- RDW_MODE, 0, same-address read-during-write: 0 = old data, 1 = new (forwarded) data.
- INIT_ZERO, 1, 1 = clear whole array after reset before accepting traffic; 0 = no clear.

Ports:
- CLK  input  1  clock; all logic on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- wr_en  input  1  write request.
- wr_be  input  LANES  per-lane write enable; bit i covers wr_data[i*LANE_LEN +: LANE_LEN].
- wr_addr  input  ADDR_LEN  write address.
- wr_data  input  DATA_LEN  write data.
- rd_en  input  1  read request.
- rd_addr  input  ADDR_LEN  read address.
- Q  output  DATA_LEN  read data.
- rd_valid  output  1  one-cycle pulse: Q carries data for an accepted read.
- busy  output  1  high while init sequencer runs; requests ignored.

Behaviour:
- Reset is asynchronous and active-low; one clock domain. Reset values: Q = 0, rd_valid = 0, internal pipeline valid/data = 0, busy = INIT_ZERO, init counter = 0. The array itself is not reset.
- FSM states: INIT, READY. Reset enters INIT if INIT_ZERO=1, else READY.
- INIT: each cycle writes 0 to the address given by the counter, then increments it. After writing DATA_WS-1, go to READY on the same edge.
  - busy = 1 for exactly DATA_WS cycles after reset release.
  - wr_en and rd_en are ignored: no write, no rd_valid.
- READY:
  - Write: on an edge with wr_en=1, only lanes with wr_be[i]=1 are updated. wr_be = 0 is a no-op.
  - Read: rd_en sampled at edge N.
    - OUT_REG=0: Q and rd_valid=1 appear after edge N.
    - OUT_REG=1: Q and rd_valid=1 appear after edge N+1.
    - Back-to-back reads give a rd_valid pulse every cycle, fully pipelined.
  - Q holds its last value when rd_valid=0.
- Read-during-write at the same address on the same edge:
  - RDW_MODE=0: return the pre-write word.
  - RDW_MODE=1: enabled lanes come from wr_data, other lanes from the stored word.
  - Different addresses do not interact.
- Reset asserted mid-INIT or mid-read: pipeline flushes (rd_valid=0, Q=0). INIT restarts from address 0 if INIT_ZERO=1.
- A write of the same address in consecutive cycles: the later write wins. A read one edge after a write returns the written data.

Test Plan:
1. ADDR_LEN=4, INIT_ZERO=1: release RST_N → busy high exactly 16 cycles. Requests issued during busy produce no rd_valid. Then read addresses 0..15 → all Q=0x00000000.
2. Write 0xAABBCCDD to addr 3, wr_be=4'b1111, then wr_data=0x11223344, wr_be=4'b0101 → read addr 3 gives 0xAA22CC44 with rd_valid 1 cycle after rd_en (OUT_REG=0).
3. OUT_REG=1: 4 back-to-back reads of addrs 0..3 holding 0x10,0x11,0x12,0x13 → rd_valid high 4 consecutive cycles starting 2 cycles after the first rd_en, data in order.
4. Addr 5 holds 0x12345678. Same-edge write 0xFFFFFFFF with wr_be=4'b0011 and read of addr 5:
   - RDW_MODE=0 → Q=0x12345678.
   - RDW_MODE=1 → Q=0x1234FFFF.
   - A following read of addr 5 → 0x1234FFFF in both modes.
5. Assert RST_N low at init cycle 7 → Q=0, busy=1 immediately. On release, busy is high for a full 16 cycles again.
6. INIT_ZERO=0 → busy=0 from reset release. A write then read on the first cycle after release completes normally.
